// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA test-pattern source.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {PAT_BARS, PAT_CHECKER, PAT_BOX, PAT_GRADIENT} pattern_e;

  // Horizontal direction first: R/L, then vertical D/U.
  typedef enum logic [1:0] {RD, RU, LD, LU} box_dir_e;

  localparam rgb_t BOX_BG = '{r: 8'h00, g: 8'h00, b: 8'h40};

  // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out of the index bits.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    bar_colour = '{r: {8{~idx[1]}}, g: {8{~idx[2]}}, b: {8{~idx[0]}}};
  endfunction

  function automatic logic checker_bit(input logic [10:0] x, input logic [10:0] scroll,
                                       input logic y5);
    logic [10:0] s;
    s = x + scroll;
    checker_bit = s[5] ^ y5;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-request / RGB-return bundle between VgaController and the pattern source.
interface vga_pattern_gen_if;
  logic [10:0] nextX;
  logic [9:0]  nextY;
  logic        vSync_n;
  logic [1:0]  Mode;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;
  logic        FrameTick;

  modport master (output nextX, nextY, vSync_n, Mode,
                  input  Red, Green, Blue, FrameTick);
  modport slave  (input  nextX, nextY, vSync_n, Mode,
                  output Red, Green, Blue, FrameTick);
endinterface

// File: rtl/vga_box_mover.sv
// Bouncing-box position: per-frame step on each axis with clamping at the active-area edges.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned STEP     = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        FrameTick,
  output logic [10:0] BoxX,
  output logic [9:0]  BoxY
);

  box_dir_e    state, state_nxt;
  logic [10:0] box_x_nxt;
  logic [9:0]  box_y_nxt;
  logic        right, down, right_nxt, down_nxt;

  assign right = (state == RD) || (state == RU);
  assign down  = (state == RD) || (state == LD);

  always_comb begin
    box_x_nxt = BoxX;
    box_y_nxt = BoxY;
    right_nxt = right;
    down_nxt  = down;

    if (right) begin
      if (32'(BoxX) + BOX_SIZE + STEP > H_ACTIVE) begin
        box_x_nxt = 11'(H_ACTIVE - BOX_SIZE);
        right_nxt = 1'b0;
      end else begin
        box_x_nxt = BoxX + 11'(STEP);
      end
    end else begin
      if (32'(BoxX) < STEP) begin
        box_x_nxt = '0;
        right_nxt = 1'b1;
      end else begin
        box_x_nxt = BoxX - 11'(STEP);
      end
    end

    if (down) begin
      if (32'(BoxY) + BOX_SIZE + STEP > V_ACTIVE) begin
        box_y_nxt = 10'(V_ACTIVE - BOX_SIZE);
        down_nxt  = 1'b0;
      end else begin
        box_y_nxt = BoxY + 10'(STEP);
      end
    end else begin
      if (32'(BoxY) < STEP) begin
        box_y_nxt = '0;
        down_nxt  = 1'b1;
      end else begin
        box_y_nxt = BoxY - 10'(STEP);
      end
    end

    case ({right_nxt, down_nxt})
      2'b11:   state_nxt = RD;
      2'b10:   state_nxt = RU;
      2'b01:   state_nxt = LD;
      default: state_nxt = LU;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      BoxX  <= '0;
      BoxY  <= '0;
      state <= RD;
    end else if (FrameTick) begin
      BoxX  <= box_x_nxt;
      BoxY  <= box_y_nxt;
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: frame detect, per-frame state, pattern mux, registered RGB.
// Optional white frame border on the active area when VGA_PATTERN_BORDER_EN is defined.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned STEP     = 2
) (
  input logic             Clock,
  input logic             Reset,
  vga_pattern_gen_if.slave bus
);

  logic        vSyncPrev;
  logic        frame_tick;
  pattern_e    ActiveMode;
  logic [7:0]  FrameCount;
  logic [10:0] Scroll;
  logic [10:0] BoxX;
  logic [9:0]  BoxY;
  logic        active, in_box;
  rgb_t        pix, rgb_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vSyncPrev  <= 1'b1;
      frame_tick <= 1'b0;
      ActiveMode <= PAT_BARS;
      FrameCount <= '0;
      Scroll     <= '0;
    end else begin
      vSyncPrev  <= bus.vSync_n;
      frame_tick <= vSyncPrev & ~bus.vSync_n;
      if (frame_tick) begin
        ActiveMode <= pattern_e'(bus.Mode);
        FrameCount <= FrameCount + 8'd1;
        Scroll     <= Scroll + 11'd1;
      end
    end
  end

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP)
  ) u_box (
    .Clock     (Clock),
    .Reset     (Reset),
    .FrameTick (frame_tick),
    .BoxX      (BoxX),
    .BoxY      (BoxY)
  );

  assign active = (32'(bus.nextX) < H_ACTIVE) && (32'(bus.nextY) < V_ACTIVE);
  assign in_box = (bus.nextX >= BoxX) && (32'(bus.nextX) < 32'(BoxX) + BOX_SIZE) &&
                  (bus.nextY >= BoxY) && (32'(bus.nextY) < 32'(BoxY) + BOX_SIZE);

  always_comb begin
    pix = '0;
    if (active) begin
      case (ActiveMode)
        PAT_BARS:     pix = bar_colour(bus.nextX[8:6]);
        PAT_CHECKER:  pix = checker_bit(bus.nextX, Scroll, bus.nextY[5]) ? '1 : '0;
        PAT_BOX:      pix = in_box ? '1 : BOX_BG;
        PAT_GRADIENT: pix = '{r: bus.nextX[9:2], g: bus.nextY[8:1], b: FrameCount};
        default:      pix = '0;
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if ((bus.nextX == '0) || (32'(bus.nextX) == H_ACTIVE - 1) ||
          (bus.nextY == '0) || (32'(bus.nextY) == V_ACTIVE - 1))
        pix = '1;
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) rgb_q <= '0;
    else       rgb_q <= pix;
  end

  assign bus.Red       = rgb_q.r;
  assign bus.Green     = rgb_q.g;
  assign bus.Blue      = rgb_q.b;
  assign bus.FrameTick = frame_tick;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed self-checking bench for vga_pattern_gen (default geometry 640x480, 32-px box, step 2).
module tb_vga_pattern_gen;
  import vga_pkg::*;

  logic Clock = 1'b0;
  logic Reset;

  vga_pattern_gen_if bus ();

  vga_pattern_gen #(
    .H_ACTIVE (640),
    .V_ACTIVE (480),
    .BOX_SIZE (32),
    .STEP     (2)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          frames;
    logic [1:0]  mode;
    logic [10:0] x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  int   checks    = 0;
  int   failures  = 0;
  int   tick_hi   = 0;
  int   tick_rise = 0;
  logic tick_prev = 1'b0;

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_rgb(input string name, input logic [23:0] exp);
    logic [23:0] act;
    act = {bus.Red, bus.Green, bus.Blue};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s rgb actual=%06h required=%06h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    if (bus.FrameTick) begin
      tick_hi++;
      if (!tick_prev) tick_rise++;
    end
    tick_prev = bus.FrameTick;
  endtask

  task automatic frame();
    bus.vSync_n = 1'b0;
    repeat (4) step();
    bus.vSync_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic pixel(input logic [10:0] x, input logic [9:0] y);
    bus.nextX = x;
    bus.nextY = y;
    step();
  endtask

  initial begin
    int          max_x, max_y, h0;
    logic [23:0] exp_border;

    // Vectors: frames to run first (with Mode applied), then one pixel request.
    vecs.push_back('{1, 2'd0, 11'd0,    10'd0,    24'hFFFFFF});
    vecs.push_back('{0, 2'd0, 11'd64,   10'd1,    24'hFFFF00});
    vecs.push_back('{0, 2'd0, 11'd128,  10'd5,    24'h00FFFF});
    vecs.push_back('{0, 2'd0, 11'd192,  10'd5,    24'h00FF00});
    vecs.push_back('{0, 2'd0, 11'd256,  10'd100,  24'hFF00FF});
    vecs.push_back('{0, 2'd0, 11'd320,  10'd100,  24'hFF0000});
    vecs.push_back('{0, 2'd0, 11'd384,  10'd100,  24'h0000FF});
    vecs.push_back('{0, 2'd0, 11'd448,  10'd100,  24'h000000});
    vecs.push_back('{0, 2'd0, 11'd512,  10'd100,  24'hFFFFFF});
    vecs.push_back('{0, 2'd0, 11'd600,  10'd200,  24'hFFFF00});
    vecs.push_back('{0, 2'd0, 11'd700,  10'd10,   24'h000000});
    vecs.push_back('{0, 2'd0, 11'd640,  10'd10,   24'h000000});
    vecs.push_back('{0, 2'd0, 11'd10,   10'd480,  24'h000000});
    vecs.push_back('{0, 2'd0, 11'd100,  10'd1000, 24'h000000});
    // Mode request changes mid-frame: bars persist until the next tick.
    vecs.push_back('{0, 2'd3, 11'd64,   10'd1,    24'hFFFF00});
    vecs.push_back('{1, 2'd3, 11'd8,    10'd4,    24'h020202});
    vecs.push_back('{0, 2'd3, 11'd400,  10'd300,  24'h649602});
    vecs.push_back('{0, 2'd3, 11'd636,  10'd200,  24'h9F6402});
    vecs.push_back('{0, 2'd3, 11'd700,  10'd10,   24'h000000});
    // Checker with Scroll = 3.
    vecs.push_back('{1, 2'd1, 11'd1,    10'd1,    24'h000000});
    vecs.push_back('{0, 2'd1, 11'd29,   10'd1,    24'hFFFFFF});
    vecs.push_back('{0, 2'd1, 11'd28,   10'd1,    24'h000000});
    vecs.push_back('{0, 2'd1, 11'd29,   10'd32,   24'h000000});
    vecs.push_back('{0, 2'd1, 11'd29,   10'd64,   24'hFFFFFF});
    vecs.push_back('{0, 2'd1, 11'd100,  10'd40,   24'h000000});
    vecs.push_back('{0, 2'd1, 11'd100,  10'd10,   24'hFFFFFF});
    // Box at (10,10) after 5 ticks total.
    vecs.push_back('{2, 2'd2, 11'd12,   10'd12,   24'hFFFFFF});
    vecs.push_back('{0, 2'd2, 11'd9,    10'd12,   24'h000040});
    vecs.push_back('{0, 2'd2, 11'd10,   10'd10,   24'hFFFFFF});
    vecs.push_back('{0, 2'd2, 11'd41,   10'd41,   24'hFFFFFF});
    vecs.push_back('{0, 2'd2, 11'd42,   10'd12,   24'h000040});
    vecs.push_back('{0, 2'd2, 11'd12,   10'd42,   24'h000040});
    vecs.push_back('{0, 2'd2, 11'd12,   10'd9,    24'h000040});

    Reset       = 1'b1;
    bus.vSync_n = 1'b1;
    bus.Mode    = 2'd0;
    bus.nextX   = '0;
    bus.nextY   = '0;
    repeat (2) step();
    check_rgb("reset_rgb", 24'h000000);
    check_val("reset_tick", int'(bus.FrameTick), 0);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.Mode = vecs[i].mode;
      repeat (vecs[i].frames) frame();
      pixel(vecs[i].x, vecs[i].y);
      check_rgb($sformatf("vec%0d", i), vecs[i].rgb);
    end

    check_val("tick_count", tick_rise, 5);
    check_val("tick_width", tick_hi, 5);
    check_val("box_x_5", int'(dut.u_box.BoxX), 10);
    check_val("box_y_5", int'(dut.u_box.BoxY), 10);

    // Long bounce run up to 305 ticks; flips happen on the tick after the edge is reached.
    max_x = 0;
    max_y = 0;
    for (int n = 6; n <= 305; n++) begin
      frame();
      if (int'(dut.u_box.BoxX) > max_x) max_x = int'(dut.u_box.BoxX);
      if (int'(dut.u_box.BoxY) > max_y) max_y = int'(dut.u_box.BoxY);
      if (n == 224) begin
        check_val("box_y_224", int'(dut.u_box.BoxY), 448);
        check_val("state_224", int'(dut.u_box.state), int'(RD));
      end
      if (n == 225) begin
        check_val("box_y_225", int'(dut.u_box.BoxY), 448);
        check_val("state_225", int'(dut.u_box.state), int'(RU));
      end
      if (n == 304) begin
        check_val("box_x_304", int'(dut.u_box.BoxX), 608);
        check_val("box_y_304", int'(dut.u_box.BoxY), 290);
        check_val("state_304", int'(dut.u_box.state), int'(RU));
      end
    end
    check_val("box_x_305", int'(dut.u_box.BoxX), 608);
    check_val("box_y_305", int'(dut.u_box.BoxY), 288);
    check_val("state_305", int'(dut.u_box.state), int'(LU));
    check_val("max_x_bound", int'(max_x <= 608), 1);
    check_val("max_y_bound", int'(max_y <= 448), 1);
    check_val("max_x_reached", max_x, 608);
    check_val("max_y_reached", max_y, 448);
    check_val("tick_count_305", tick_rise, 305);
    check_val("tick_width_305", tick_hi, 305);
    pixel(11'd620, 10'd300);
    check_rgb("box_corner_in", 24'hFFFFFF);
    pixel(11'd607, 10'd300);
    check_rgb("box_corner_left", 24'h000040);
    pixel(11'd620, 10'd287);
    check_rgb("box_corner_above", 24'h000040);

    // Gradient blue tracks FrameCount: 306 ticks wraps to 50.
    bus.Mode = 2'd3;
    frame();
    pixel(11'd8, 10'd4);
    check_rgb("grad_fc", 24'h020232);

    // Reset mid-frame.
    bus.nextX = 11'd100;
    bus.nextY = 10'd100;
    Reset     = 1'b1;
    step();
    check_rgb("midreset_rgb", 24'h000000);
    check_val("midreset_tick", int'(bus.FrameTick), 0);
    check_val("midreset_box_x", int'(dut.u_box.BoxX), 0);
    check_val("midreset_box_y", int'(dut.u_box.BoxY), 0);
    check_val("midreset_state", int'(dut.u_box.state), int'(RD));
    check_val("midreset_fc", int'(dut.FrameCount), 0);
    check_val("midreset_scroll", int'(dut.Scroll), 0);
    Reset = 1'b0;
    pixel(11'd64, 10'd1);
    check_rgb("midreset_mode_bars", 24'hFFFF00);

    // Reset held across a whole vsync pulse: no tick for that edge.
    h0    = tick_hi;
    Reset = 1'b1;
    step();
    bus.vSync_n = 1'b0;
    repeat (3) step();
    bus.vSync_n = 1'b1;
    step();
    Reset = 1'b0;
    repeat (3) step();
    check_val("reset_held_tick", tick_hi - h0, 0);
    check_val("reset_held_fc", int'(dut.FrameCount), 0);

    // Left-edge pixel beside the box at (2,2).
    bus.Mode = 2'd2;
    frame();
`ifdef VGA_PATTERN_BORDER_EN
    exp_border = 24'hFFFFFF;
`else
    exp_border = 24'h000040;
`endif
    pixel(11'd0, 10'd100);
    check_rgb("edge_pixel", exp_border);
    pixel(11'd3, 10'd3);
    check_rgb("box_after_reset", 24'hFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
